// File: rtl/mux_pkg.sv
// Shared definitions for the registered 4-way datapath operand mux.
// Select codes are an enum so every user decodes the same encoding.
package mux_pkg;

  localparam int unsigned MUX_WIDTH = 16;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_e;

endpackage : mux_pkg

// File: rtl/mux2_16.sv
// 2-way WIDTH-bit mux stage: z = s ? y : x.
module mux2_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             s,
  output logic [WIDTH-1:0] z
);

  always_comb begin
    z = s ? y : x;
  end

endmodule : mux2_16

// File: rtl/mux_4way_16.sv
// Registered 4-to-1 WIDTH-bit mux built from three 2-way stages.
// Define MUX4_PARITY_EN to add the registered even-parity output out_par.
module mux_4way_16
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
`ifdef MUX4_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] pick_ab;
  logic [WIDTH-1:0] pick_cd;
  logic [WIDTH-1:0] pick;

  // sel[0] chooses within each pair, sel[1] chooses the pair.
  mux2_16 #(.WIDTH(WIDTH)) stage0 (.x(a),       .y(b),       .s(sel[0]), .z(pick_ab));
  mux2_16 #(.WIDTH(WIDTH)) stage1 (.x(c),       .y(d),       .s(sel[0]), .z(pick_cd));
  mux2_16 #(.WIDTH(WIDTH)) stage2 (.x(pick_ab), .y(pick_cd), .s(sel[1]), .z(pick));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
`ifdef MUX4_PARITY_EN
      out_par <= 1'b0;
`endif
    end else if (en) begin
      out     <= pick;
`ifdef MUX4_PARITY_EN
      out_par <= ^pick;
`endif
    end
  end

endmodule : mux_4way_16

// File: tb/tb_mux_4way_16.sv
// Directed scoreboard bench for mux_4way_16 (parity checks with MUX4_PARITY_EN).
module tb_mux_4way_16;
  import mux_pkg::*;

  typedef struct {
    logic [15:0] val;
    logic        par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] a, b, c, d;
  logic [1:0]  sel;
  logic [15:0] out;
`ifdef MUX4_PARITY_EN
  logic        out_par;
`endif

  exp_t        sb[$];
  logic [15:0] model_val;
  logic        model_par;
  int          checks = 0;
  int          fails  = 0;

  mux_4way_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .out   (out)
`ifdef MUX4_PARITY_EN
    ,
    .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ref_pick(input logic [1:0] s, input logic [15:0] va,
                                           input logic [15:0] vb, input logic [15:0] vc,
                                           input logic [15:0] vd);
    case (s)
      2'b00:   return va;
      2'b01:   return vb;
      2'b10:   return vc;
      default: return vd;
    endcase
  endfunction

  task automatic push_model();
    exp_t e;
    e.val = model_val;
    e.par = model_par;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s: scoreboard empty, got out=%h, expected an entry", tag, out);
      return;
    end
    e = sb.pop_front();
    assert (out === e.val) else begin
      fails++;
      $error("FAIL %s: out got %h, expected %h", tag, out, e.val);
    end
`ifdef MUX4_PARITY_EN
    checks++;
    assert (out_par === e.par) else begin
      fails++;
      $error("FAIL %s_par: out_par got %b, expected %b", tag, out_par, e.par);
    end
`endif
  endtask

  // Drive inputs mid-cycle, predict the register, then check #1 after the edge.
  task automatic step(input string tag, input logic e, input logic [1:0] s,
                      input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] vc, input logic [15:0] vd);
    logic [15:0] p;
    en = e; sel = s; a = va; b = vb; c = vc; d = vd;
    p = ref_pick(s, va, vb, vc, vd);
    if (e && rst_n) begin
      model_val = p;
      model_par = ^p;
    end
    push_model();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = SEL_A;
    a = 16'ha211; b = '0; c = '0; d = '0;
    model_val = '0; model_par = 1'b0;

    // Reset value visible before any clock edge.
    #2;
    push_model();
    check("reset_no_clk");

    rst_n = 1'b1;
    step("release_load", 1'b1, SEL_A, 16'ha211, 16'h0000, 16'h0000, 16'h0000);

    step("sweep_b", 1'b1, SEL_B, 16'h0000, 16'h0001, 16'h0010, 16'h1000);
    step("sweep_c", 1'b1, SEL_C, 16'h0000, 16'h0001, 16'h0010, 16'h1000);
    step("sweep_d", 1'b1, SEL_D, 16'h0000, 16'h0001, 16'h0010, 16'h1000);
    step("sweep_a", 1'b1, SEL_A, 16'h0000, 16'h0001, 16'h0010, 16'h1000);

    step("iso_d",   1'b1, SEL_D, 16'h0000, 16'h0001, 16'h0010, 16'h1000);
    step("iso_a_b", 1'b1, SEL_D, 16'h1001, 16'ha211, 16'h0010, 16'h1000);
    step("iso_c",   1'b1, SEL_D, 16'h1001, 16'ha211, 16'h5a5a, 16'h1000);
    step("iso_back",1'b1, SEL_A, 16'h0211, 16'ha211, 16'h5a5a, 16'h1000);

    for (int unsigned i = 0; i < 3; i++)
      step("hold", 1'b0, SEL_D, 16'h0211, 16'ha211, 16'h5a5a, 16'hffff);
    step("hold_release", 1'b1, SEL_D, 16'h0211, 16'ha211, 16'h5a5a, 16'hffff);

    // Mid-operation reset between edges while sel toggles every cycle.
    step("toggle0", 1'b1, SEL_B, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    step("toggle1", 1'b1, SEL_C, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    #2;
    rst_n = 1'b0;
    model_val = '0; model_par = 1'b0;
    #1;
    push_model();
    check("midop_reset");
    step("reset_held_edge", 1'b1, SEL_D, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    rst_n = 1'b1;
    step("resume", 1'b1, SEL_B, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    step("par_3", 1'b1, SEL_A, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
    step("par_1", 1'b1, SEL_A, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    step("par_hold", 1'b0, SEL_C, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
    #2;
    rst_n = 1'b0;
    model_val = '0; model_par = 1'b0;
    #1;
    push_model();
    check("par_reset");
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 16; i++)
      step("random", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_mux_4way_16
